// File: rtl/dt_param_gen_if.sv
// Handshake and result bundle for the dt parameter generator.
interface dt_param_gen_if #(
    parameter int DBL_WIDTH = 64
);
    logic                 start;
    logic [DBL_WIDTH-1:0] delta_t;
    logic                 busy;
    logic                 done;
    logic                 params_valid;
    logic [DBL_WIDTH-1:0] dt_out;
    logic [DBL_WIDTH-1:0] dt2;
    logic [DBL_WIDTH-1:0] half_dt2;
    logic [DBL_WIDTH-1:0] three2_dt2;
    logic [DBL_WIDTH-1:0] half_dt3;

    modport master (
        output start, delta_t,
        input  busy, done, params_valid,
        input  dt_out, dt2, half_dt2, three2_dt2, half_dt3
    );

    modport slave (
        input  start, delta_t,
        output busy, done, params_valid,
        output dt_out, dt2, half_dt2, three2_dt2, half_dt3
    );
endinterface

// File: rtl/dt_param_gen.sv
// Derives dt, dt^2, dt^2/2, 3dt^2/2, dt^3/2 from delta_t on one shared multiplier.
// Optional cache-hit fast path enabled by defining DT_PARAM_CACHE_EN.
module fp_multiplier (
    input  logic        clk,
    input  logic        valid,
    output logic        finish,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result
);
    logic         s;
    logic [10:0]  ea, eb, ex;
    logic [51:0]  fa, fb, frac;
    logic [105:0] prod;
    logic [52:0]  norm;
    logic [53:0]  rnd;
    logic [13:0]  eb_sum;
    logic         g, st, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [63:0]  res;

    // Subnormals are flushed to signed zero; rounding is nearest-even.
    always_comb begin
        s      = a[63] ^ b[63];
        ea     = a[62:52];
        eb     = b[62:52];
        fa     = a[51:0];
        fb     = b[51:0];
        a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
        b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
        a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
        b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
        a_zero = (ea == 11'd0);
        b_zero = (eb == 11'd0);
        prod   = {1'b1, fa} * {1'b1, fb};
        eb_sum = {3'b0, ea} + {3'b0, eb};
        if (prod[105]) begin
            norm   = prod[105:53];
            g      = prod[52];
            st     = |prod[51:0];
            eb_sum = eb_sum + 14'd1;
        end else begin
            norm = prod[104:52];
            g    = prod[51];
            st   = |prod[50:0];
        end
        rnd = {1'b0, norm} + {53'd0, g & (st | norm[0])};
        if (rnd[53]) begin
            eb_sum = eb_sum + 14'd1;
            frac   = rnd[52:1];
        end else begin
            frac = rnd[51:0];
        end
        ex = eb_sum[10:0] - 11'd1023;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = {1'b0, 11'h7FF, 1'b1, 51'd0};
        else if (a_inf || b_inf)
            res = {s, 11'h7FF, 52'd0};
        else if (a_zero || b_zero)
            res = {s, 63'd0};
        else if (eb_sum >= 14'd3070)
            res = {s, 11'h7FF, 52'd0};
        else if (eb_sum <= 14'd1023)
            res = {s, 63'd0};
        else
            res = {s, ex, frac};
    end

    always_ff @(posedge clk) begin
        finish <= valid;
        if (valid) result <= res;
    end
endmodule

module dt_param_gen #(
    parameter int DBL_WIDTH = 64
) (
    input logic           clk,
    input logic           rst_n,
    dt_param_gen_if.slave bus
);
    localparam logic [DBL_WIDTH-1:0] C_3_2  = 64'h3FF8000000000000;
    localparam logic [DBL_WIDTH-1:0] C_HALF = 64'h3FE0000000000000;

    typedef enum logic [2:0] {
        IDLE, MUL_DT2, MUL_DT3, MUL_T2, MUL_H2, MUL_H3, DONE
    } state_e;

    state_e               state_q;
    logic                 busy_q, done_q, pv_q, mul_valid_q;
    logic [DBL_WIDTH-1:0] dt_r_q, dt3_q, dt_out_q, dt2_q;
    logic [DBL_WIDTH-1:0] half_dt2_q, three2_dt2_q, half_dt3_q;
    logic [DBL_WIDTH-1:0] mul_a, mul_b, mul_res;
    logic                 mul_finish;

    fp_multiplier u_mul (
        .clk    (clk),
        .valid  (mul_valid_q),
        .finish (mul_finish),
        .a      (mul_a),
        .b      (mul_b),
        .result (mul_res)
    );

    always_comb begin
        mul_a = dt2_q;
        mul_b = dt_r_q;
        unique case (state_q)
            MUL_DT2: begin mul_a = dt_r_q; mul_b = dt_r_q; end
            MUL_DT3: begin mul_a = dt2_q;  mul_b = dt_r_q; end
            MUL_T2:  begin mul_a = dt2_q;  mul_b = C_3_2;  end
            MUL_H2:  begin mul_a = dt2_q;  mul_b = C_HALF; end
            MUL_H3:  begin mul_a = dt3_q;  mul_b = C_HALF; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pv_q         <= 1'b0;
            mul_valid_q  <= 1'b0;
            dt_r_q       <= '0;
            dt3_q        <= '0;
            dt_out_q     <= '0;
            dt2_q        <= '0;
            half_dt2_q   <= '0;
            three2_dt2_q <= '0;
            half_dt3_q   <= '0;
        end else begin
            mul_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (bus.start) begin
`ifdef DT_PARAM_CACHE_EN
                        if (pv_q && (bus.delta_t == dt_out_q)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else
`endif
                        begin
                            dt_r_q      <= bus.delta_t;
                            dt_out_q    <= bus.delta_t;
                            pv_q        <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= MUL_DT2;
                            mul_valid_q <= 1'b1;
                        end
                    end
                end
                MUL_DT2: if (mul_finish) begin
                    dt2_q       <= mul_res;
                    state_q     <= MUL_DT3;
                    mul_valid_q <= 1'b1;
                end
                MUL_DT3: if (mul_finish) begin
                    dt3_q       <= mul_res;
                    state_q     <= MUL_T2;
                    mul_valid_q <= 1'b1;
                end
                MUL_T2: if (mul_finish) begin
                    three2_dt2_q <= mul_res;
                    state_q      <= MUL_H2;
                    mul_valid_q  <= 1'b1;
                end
                MUL_H2: if (mul_finish) begin
                    half_dt2_q  <= mul_res;
                    state_q     <= MUL_H3;
                    mul_valid_q <= 1'b1;
                end
                MUL_H3: if (mul_finish) begin
                    half_dt3_q <= mul_res;
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    pv_q       <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.params_valid = pv_q;
    assign bus.dt_out       = dt_out_q;
    assign bus.dt2          = dt2_q;
    assign bus.half_dt2     = half_dt2_q;
    assign bus.three2_dt2   = three2_dt2_q;
    assign bus.half_dt3     = half_dt3_q;
endmodule
